ysyx_22040931_dmem_slave: RTL and testbench

YSYX_22040931_DMEM_SLAVE -- requirements
Module: ysyx_22040931_dmem_slave

---
 rtl/ysyx_22040931_dmem_slave_pkg.sv | 32 +++
 rtl/ysyx_22040931_dmem_slave_wmask_gen.sv | 23 ++
 rtl/ysyx_22040931_dmem_slave.sv | 143 ++++++++++++++
 tb/tb_ysyx_22040931_dmem_slave.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040931_dmem_slave_pkg.sv
// Shared definitions for the ysyx_22040931 data-memory path.
// Holds the access-size encodings, the default memory base and the slave FSM states.
package ysyx_22040931_dmem_slave_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } size_e;

    localparam logic [63:0] DEFAULT_BASE = 64'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Address bits that must be zero for a naturally aligned access of this size.
    function automatic logic [2:0] size_align_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size_e'(size))
            SIZE_B:  m = 3'b000;
            SIZE_H:  m = 3'b001;
            SIZE_W:  m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ysyx_22040931_dmem_slave_wmask_gen.sv
// Byte-lane mask and misalignment flag from access size and the low address bits.
// Purely combinational so the core's MEM stage can reuse it directly.
module ysyx_22040931_wmask_gen
    import ysyx_22040931_dmem_slave_pkg::*;
(
    input  logic [1:0] size,
    input  logic [2:0] addr_lo,
    output logic [7:0] byte_mask,
    output logic       misalign
);

    always_comb begin
        byte_mask = 8'h00;
        case (size_e'(size))
            SIZE_B:  byte_mask = 8'h01 << addr_lo;
            SIZE_H:  byte_mask = 8'h03 << addr_lo;
            SIZE_W:  byte_mask = 8'h0F << addr_lo;
            default: byte_mask = 8'hFF;
        endcase
        misalign = |(addr_lo & size_align_mask(size));
    end

endmodule

// File: rtl/ysyx_22040931_dmem_slave.sv
// Data-memory slave: one request in flight, fixed LATENCY from accept to response,
// DEPTH x 64-bit storage with per-byte write enable; stores commit as the response is formed.
module ysyx_22040931_dmem_slave
    import ysyx_22040931_dmem_slave_pkg::*;
#(
    parameter int          DEPTH   = 512,
    parameter logic [63:0] BASE    = DEFAULT_BASE,
    parameter int          LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] SPAN     = 64'(DEPTH) << 3;
    localparam logic [1:0]  CNT_LAST = 2'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [63:0] mem_q [DEPTH];

    logic [63:0]      offset;
    logic [IDX_W-1:0] word_idx;
    logic [7:0]       byte_mask;
    logic             misalign;
    logic             out_of_range;
    logic             req_err;
    logic             commit;
    logic             mem_we;
    logic [63:0]      lane_data;

    ysyx_22040931_wmask_gen u_wmask_gen (
        .size      (size_q),
        .addr_lo   (addr_q[2:0]),
        .byte_mask (byte_mask),
        .misalign  (misalign)
    );

    // Everything below works on the captured request, never on the live inputs.
    always_comb begin
        offset       = addr_q - BASE;
        word_idx     = offset[IDX_W+2:3];
        out_of_range = (addr_q < BASE) || (offset >= SPAN);
        req_err      = out_of_range || misalign;
        lane_data    = wdata_q << {addr_q[2:0], 3'b000};
        commit       = (state_q == ST_BUSY) && (cnt_q == CNT_LAST);
        mem_we       = commit && wr_q && !req_err && !reset;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_BUSY;
                    cnt_d   = 2'd0;
                    wr_d    = req_wr;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            ST_BUSY: begin
                if (commit) begin
                    state_d = ST_RESP;
                    rdata_d = (wr_q || req_err) ? 64'd0 : mem_q[word_idx];
                    err_d   = req_err;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = 64'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately left out of reset; a reset on the commit edge blocks the write.
    always_ff @(posedge clock) begin
        for (int b = 0; b < 8; b++) begin
            if (mem_we && byte_mask[b]) begin
                mem_q[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_ysyx_22040931_dmem_slave.sv
// Bench for ysyx_22040931_dmem_slave: a LATENCY=1 and a LATENCY=4 instance checked
// against a byte-addressed reference memory.
module tb_ysyx_22040931_dmem_slave;

    localparam int          DEPTH = 16;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  rsp_ready = 2'b00;
    logic        req_wr = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic [1:0]  req_ready_o;
    logic [1:0]  rsp_valid_o;
    logic [63:0] rdata_o [2];
    logic [1:0]  err_o;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [7:0] ref_mem [2][DEPTH*8];

    always #5 clock = ~clock;

    ysyx_22040931_dmem_slave #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) dut_lat1 (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid[0]),
        .req_ready (req_ready_o[0]),
        .req_wr    (req_wr),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid_o[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rdata_o[0]),
        .rsp_err   (err_o[0])
    );

    ysyx_22040931_dmem_slave #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(4)) dut_lat4 (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid[1]),
        .req_ready (req_ready_o[1]),
        .req_wr    (req_wr),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid_o[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rdata_o[1]),
        .rsp_err   (err_o[1])
    );

    // Reference: memory as a flat byte array; an access is legal when in range and naturally aligned.
    function automatic void model_access(input int sel, input bit wr, input logic [1:0] size,
                                         input logic [63:0] addr, input logic [63:0] wdata,
                                         output logic [63:0] rdata, output logic err);
        int          nbytes;
        int          word_base;
        logic [63:0] off;
        nbytes = 1 << size;
        off    = addr - BASE;
        err    = (addr < BASE) || (addr >= BASE + 64'(DEPTH*8)) || ((addr % 64'(nbytes)) != 64'd0);
        rdata  = 64'd0;
        if (!err) begin
            if (wr) begin
                for (int i = 0; i < nbytes; i++) ref_mem[sel][int'(off) + i] = wdata[8*i +: 8];
            end else begin
                word_base = int'(off) & ~7;
                for (int i = 0; i < 8; i++) rdata[8*i +: 8] = ref_mem[sel][word_base + i];
            end
        end
    endfunction

    // One full request/response exchange, with inputs scrambled after accept and a
    // request held up against the busy slave during the response.
    task automatic run_txn(input int sel, input bit wr, input logic [1:0] size,
                           input logic [63:0] addr, input logic [63:0] wdata, input int stall,
                           output logic [63:0] got_rdata, output logic got_err);
        logic [63:0] exp_rdata;
        logic        exp_err;
        int          n;
        int          lat;
        lat = (sel == 0) ? 1 : 4;
        model_access(sel, wr, size, addr, wdata, exp_rdata, exp_err);
        req_wr    = wr;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid[sel] = 1'b1;
        n_compared++;
        if (req_ready_o[sel] !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL req_ready_idle dut%0d: got %b want 1", sel, req_ready_o[sel]);
        end
        @(posedge clock); #1;
        req_valid[sel] = 1'b0;
        req_wr    = 1'($urandom);
        req_size  = 2'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        n = 0;
        while (rsp_valid_o[sel] !== 1'b1 && n < 20) begin
            n_compared++;
            if (req_ready_o[sel] !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL req_ready_busy dut%0d: got %b want 0", sel, req_ready_o[sel]);
            end
            @(posedge clock); #1;
            n++;
        end
        n_compared++;
        if (n !== lat) begin
            n_mismatched++;
            $display("[TB] FAIL latency dut%0d addr %h: got %0d cycles want %0d", sel, addr, n, lat);
        end
        got_rdata = rdata_o[sel];
        got_err   = err_o[sel];
        req_valid[sel] = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(posedge clock); #1;
            n_compared++;
            if (rsp_valid_o[sel] !== 1'b1 || req_ready_o[sel] !== 1'b0 ||
                rdata_o[sel] !== got_rdata || err_o[sel] !== got_err) begin
                n_mismatched++;
                $display("[TB] FAIL hold dut%0d: got v=%b rdy=%b d=%h e=%b want v=1 rdy=0 d=%h e=%b",
                         sel, rsp_valid_o[sel], req_ready_o[sel], rdata_o[sel], err_o[sel], got_rdata, got_err);
            end
        end
        n_compared++;
        if (got_rdata !== exp_rdata) begin
            n_mismatched++;
            $display("[TB] FAIL rdata dut%0d wr=%b size=%0d addr %h: got %h want %h",
                     sel, wr, size, addr, got_rdata, exp_rdata);
        end
        n_compared++;
        if (got_err !== exp_err) begin
            n_mismatched++;
            $display("[TB] FAIL err dut%0d size=%0d addr %h: got %b want %b", sel, size, addr, got_err, exp_err);
        end
        rsp_ready[sel] = 1'b1;
        @(posedge clock); #1;
        rsp_ready[sel] = 1'b0;
        req_valid[sel] = 1'b0;
        n_compared++;
        if (rsp_valid_o[sel] !== 1'b0 || req_ready_o[sel] !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL handshake dut%0d: got v=%b rdy=%b want v=0 rdy=1",
                     sel, rsp_valid_o[sel], req_ready_o[sel]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            n_compared++;
            if (req_ready_o[s] !== 1'b1 || rsp_valid_o[s] !== 1'b0 || rdata_o[s] !== 64'd0 || err_o[s] !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_state dut%0d: got rdy=%b v=%b d=%h e=%b want 1 0 0 0",
                         s, req_ready_o[s], rsp_valid_o[s], rdata_o[s], err_o[s]);
            end
        end
    endtask

    task automatic test_init();
        logic [63:0] d;
        logic        e;
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < DEPTH; w++)
                run_txn(s, 1'b1, 2'd3, BASE + 64'(w*8), {$urandom, $urandom}, 0, d, e);
    endtask

    task automatic test_store_load();
        logic [63:0] d;
        logic        e;
        run_txn(0, 1'b1, 2'd3, 64'h8000_0008, 64'h1122334455667788, 0, d, e);
        run_txn(0, 1'b0, 2'd3, 64'h8000_0008, 64'd0, 0, d, e);
        n_compared++;
        if (d !== 64'h1122334455667788 || e !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL store_load_d: got %h err %b want 1122334455667788 err 0", d, e);
        end
    endtask

    task automatic test_byte_half();
        logic [63:0] d;
        logic        e;
        run_txn(0, 1'b1, 2'd0, 64'h8000_000B, 64'h0000_0000_0000_00AB, 0, d, e);
        run_txn(0, 1'b0, 2'd3, 64'h8000_0008, 64'd0, 0, d, e);
        n_compared++;
        if (d !== 64'h11223344AB667788) begin
            n_mismatched++;
            $display("[TB] FAIL store_byte: got %h want 11223344ab667788", d);
        end
        run_txn(0, 1'b1, 2'd1, 64'h8000_0008, 64'h0000_0000_0000_CDEF, 1, d, e);
        run_txn(0, 1'b0, 2'd3, 64'h8000_0008, 64'd0, 0, d, e);
        n_compared++;
        if (d !== 64'h11223344AB66CDEF) begin
            n_mismatched++;
            $display("[TB] FAIL store_half: got %h want 11223344ab66cdef", d);
        end
    endtask

    task automatic test_errors();
        logic [63:0] d;
        logic        e;
        run_txn(0, 1'b0, 2'd2, 64'h8000_0002, 64'd0, 0, d, e);
        n_compared++;
        if (e !== 1'b1 || d !== 64'd0) begin
            n_mismatched++;
            $display("[TB] FAIL misaligned_w: got d=%h e=%b want d=0 e=1", d, e);
        end
        run_txn(0, 1'b1, 2'd3, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 0, d, e);
        n_compared++;
        if (e !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL below_base: got e=%b want 1", e);
        end
        run_txn(1, 1'b1, 2'd3, BASE + 64'(DEPTH*8), 64'hFFFF_FFFF_FFFF_FFFF, 0, d, e);
        run_txn(1, 1'b1, 2'd1, 64'h8000_0011, 64'h1234, 0, d, e);
        run_txn(0, 1'b0, 2'd3, 64'h8000_0008, 64'd0, 0, d, e);
        n_compared++;
        if (d !== 64'h11223344AB66CDEF) begin
            n_mismatched++;
            $display("[TB] FAIL err_no_write: got %h want 11223344ab66cdef", d);
        end
    endtask

    task automatic test_latency4_stall();
        logic [63:0] d;
        logic        e;
        run_txn(1, 1'b0, 2'd3, BASE, 64'd0, 5, d, e);
        run_txn(1, 1'b1, 2'd2, BASE + 64'd4, 64'hCAFE_F00D, 3, d, e);
        run_txn(1, 1'b0, 2'd3, BASE, 64'd0, 0, d, e);
    endtask

    task automatic test_reset_busy();
        logic [63:0] d;
        logic        e;
        for (int s = 0; s < 2; s++) begin
            req_wr    = 1'b1;
            req_size  = 2'd2;
            req_addr  = 64'h8000_0010;
            req_wdata = 64'h0000_0000_DEAD_BEEF;
            req_valid[s] = 1'b1;
            @(posedge clock); #1;
            req_valid[s] = 1'b0;
            if (s == 1) begin
                repeat (2) begin @(posedge clock); #1; end
            end
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
            n_compared++;
            if (rsp_valid_o[s] !== 1'b0 || req_ready_o[s] !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL reset_busy_state dut%0d: got v=%b rdy=%b want v=0 rdy=1",
                         s, rsp_valid_o[s], req_ready_o[s]);
            end
            run_txn(s, 1'b0, 2'd3, 64'h8000_0010, 64'd0, 0, d, e);
        end
    endtask

    task automatic test_reset_resp();
        int n;
        req_wr    = 1'b0;
        req_size  = 2'd3;
        req_addr  = BASE;
        req_valid[1] = 1'b1;
        @(posedge clock); #1;
        req_valid[1] = 1'b0;
        n = 0;
        while (rsp_valid_o[1] !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        n_compared++;
        if (rsp_valid_o[1] !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL reset_resp_timeout: got v=%b want 1", rsp_valid_o[1]);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        n_compared++;
        if (rsp_valid_o[1] !== 1'b0 || req_ready_o[1] !== 1'b1 || err_o[1] !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_resp_drop: got v=%b rdy=%b e=%b want 0 1 0",
                     rsp_valid_o[1], req_ready_o[1], err_o[1]);
        end
    endtask

    task automatic test_random();
        logic [63:0] d;
        logic        e;
        logic [63:0] addr;
        logic [1:0]  size;
        int          sel;
        int          nb;
        int          r;
        for (int k = 0; k < 120; k++) begin
            sel  = int'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            nb   = 1 << size;
            r    = int'($urandom_range(0, 15));
            if (r == 0) begin
                addr = BASE - 64'($urandom_range(1, 16));
            end else if (r == 1) begin
                addr = BASE + 64'(DEPTH*8) + 64'($urandom_range(0, 15));
            end else begin
                addr = BASE + 64'($urandom_range(0, DEPTH*8 - 1));
                if (r > 4) addr = addr & ~64'(nb - 1);
            end
            run_txn(sel, 1'($urandom), size, addr, {$urandom, $urandom},
                    int'($urandom_range(0, 2)), d, e);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_store_load();
        test_byte_half();
        test_errors();
        test_latency4_stall();
        test_reset_busy();
        test_reset_resp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
